// File: rtl/dial_pkg.sv
// Shared types for the dial coprocessor: FSM state encoding, dout select codes
// and the control-word bit position of the soft clear.
package dial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_NORM = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [2:0] SEL_DIN   = 3'b000;
    localparam logic [2:0] SEL_DELTA = 3'b001;
    localparam logic [2:0] SEL_POS   = 3'b010;
    localparam logic [2:0] SEL_LAND  = 3'b011;
    localparam logic [2:0] SEL_CROSS = 3'b100;

    localparam int CTRL_CLEAR_BIT = 3;

endpackage

// File: rtl/dial_norm.sv
// Iterative modulo-N normaliser: folds a signed sum back into [0, N) with one
// add/subtract of N per cycle, counting how many folds were needed.
module dial_norm
    import dial_pkg::*;
#(
    parameter int WIDTH_COMPUTE = 32,
    parameter int DIAL_SIZE     = 100
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic                     step,
    input  logic [WIDTH_COMPUTE:0]   tmp_init,
    output logic [WIDTH_COMPUTE:0]   tmp,
    output logic [WIDTH_COMPUTE-1:0] corr_cnt,
    output logic                     in_range
);

    localparam logic signed [WIDTH_COMPUTE:0] MOD = (WIDTH_COMPUTE+1)'(DIAL_SIZE);

    logic signed [WIDTH_COMPUTE:0] tmp_q, tmp_d;
    logic [WIDTH_COMPUTE-1:0]      corr_q, corr_d;
    logic                          in_range_q, in_range_d;

    // in_range is only raised on a step that found nothing to correct, so the
    // owner sees it one cycle after the last fold.
    always_comb begin
        tmp_d      = tmp_q;
        corr_d     = corr_q;
        in_range_d = in_range_q;
        if (load) begin
            tmp_d      = $signed(tmp_init);
            corr_d     = '0;
            in_range_d = 1'b0;
        end else if (step && !in_range_q) begin
            if (tmp_q[WIDTH_COMPUTE]) begin
                tmp_d  = tmp_q + MOD;
                corr_d = corr_q + WIDTH_COMPUTE'(1);
            end else if (tmp_q >= MOD) begin
                tmp_d  = tmp_q - MOD;
                corr_d = corr_q + WIDTH_COMPUTE'(1);
            end else begin
                in_range_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmp_q      <= '0;
            corr_q     <= '0;
            in_range_q <= 1'b0;
        end else begin
            tmp_q      <= tmp_d;
            corr_q     <= corr_d;
            in_range_q <= in_range_d;
        end
    end

    assign tmp      = tmp_q;
    assign corr_cnt = corr_q;
    assign in_range = in_range_q;

endmodule

// File: rtl/dial_coprocessor.sv
// Rotary dial coprocessor: applies signed rotation deltas to a modulo-N dial
// position and counts landings on zero and clicks passing through zero.
module dial_coprocessor
    import dial_pkg::*;
#(
    parameter int WIDTH_DIN     = 128,
    parameter int WIDTH_DOUT    = 128,
    parameter int WIDTH_COMPUTE = 32,
    parameter int DIAL_SIZE     = 100,
    parameter int START_POS     = 50
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH_DIN-1:0]  din,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic [WIDTH_DOUT-1:0] dout,
    output logic                  dout_valid,
    input  logic [5:0]            control
);

    localparam int W = WIDTH_COMPUTE;
    localparam logic [W-1:0] START_W = WIDTH_COMPUTE'(START_POS);

    state_e                 state_q, state_d;
    logic [WIDTH_DIN-1:0]   din_q, din_d;
    logic [W-1:0]           delta_q, delta_d;
    logic [W-1:0]           pos_q, pos_d;
    logic [W-1:0]           land_q, land_d;
    logic [W-1:0]           cross_q, cross_d;
    logic                   dout_valid_q, dout_valid_d;

    logic                   clear_req;
    logic                   norm_load, norm_step, norm_in_range;
    logic [W:0]             tmp_init, norm_tmp;
    logic [W-1:0]           norm_corr;
    logic                   delta_neg, tmp_zero, pos_was_zero;
    logic [1:0]             unused_ctrl;

    assign clear_req   = control[CTRL_CLEAR_BIT];
    assign unused_ctrl = control[5:4];
    assign din_ready   = (state_q == ST_IDLE) && !clear_req;

    // Position is zero-extended and delta sign-extended so the W+1 bit sum
    // is the exact signed result for any in-range delta.
    assign tmp_init     = {1'b0, pos_q} + {delta_q[W-1], delta_q};
    assign delta_neg    = delta_q[W-1];
    assign tmp_zero     = (norm_tmp == '0);
    assign pos_was_zero = (pos_q == '0);

    dial_norm #(
        .WIDTH_COMPUTE (WIDTH_COMPUTE),
        .DIAL_SIZE     (DIAL_SIZE)
    ) u_norm (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (norm_load),
        .step     (norm_step),
        .tmp_init (tmp_init),
        .tmp      (norm_tmp),
        .corr_cnt (norm_corr),
        .in_range (norm_in_range)
    );

    always_comb begin
        state_d      = state_q;
        din_d        = din_q;
        delta_d      = delta_q;
        pos_d        = pos_q;
        land_d       = land_q;
        cross_d      = cross_q;
        dout_valid_d = 1'b0;
        norm_load    = 1'b0;
        norm_step    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    pos_d   = START_W;
                    land_d  = '0;
                    cross_d = '0;
                end else if (din_valid) begin
                    din_d   = din;
                    delta_d = din[W-1:0];
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                norm_load = 1'b1;
                state_d   = ST_NORM;
            end
            ST_NORM: begin
                norm_step = 1'b1;
                if (norm_in_range) begin
                    // A left turn ending on 0 counts that landing as a click;
                    // one starting on 0 must not count leaving it.
                    pos_d        = norm_tmp[W-1:0];
                    land_d       = land_q + W'(tmp_zero);
                    cross_d      = cross_q + norm_corr
                                 + W'(delta_neg && tmp_zero)
                                 - W'(delta_neg && pos_was_zero);
                    dout_valid_d = 1'b1;
                    state_d      = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            din_q        <= '0;
            delta_q      <= '0;
            pos_q        <= START_W;
            land_q       <= '0;
            cross_q      <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            din_q        <= din_d;
            delta_q      <= delta_d;
            pos_q        <= pos_d;
            land_q       <= land_d;
            cross_q      <= cross_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    always_comb begin
        case (control[2:0])
            SEL_DIN:   dout = WIDTH_DOUT'(din_q);
            SEL_DELTA: dout = WIDTH_DOUT'($signed(delta_q));
            SEL_POS:   dout = WIDTH_DOUT'(pos_q);
            SEL_LAND:  dout = WIDTH_DOUT'(land_q);
            SEL_CROSS: dout = WIDTH_DOUT'(cross_q);
            default:   dout = '0;
        endcase
    end

    assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_dial_coprocessor.sv
// Self-checking bench for dial_coprocessor: spec vectors, handshake/clear/reset
// corner sequences and randomized rotations against an arithmetic dial model.
module tb_dial_coprocessor;

    localparam longint N = 100;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] din;
    logic         din_valid;
    logic         din_ready;
    logic [127:0] dout;
    logic         dout_valid;
    logic [5:0]   control;

    int n_tests = 0;
    int n_fail  = 0;

    longint       m_pos;
    logic [31:0]  m_land;
    logic [31:0]  m_cross;
    logic [127:0] m_din;

    typedef struct {
        longint delta;
        longint exp_pos;
        int     exp_lat;
    } vec_t;

    vec_t tbl [10];

    dial_coprocessor dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .control    (control)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic longint mod_n(input longint x);
        return ((x % N) + N) % N;
    endfunction

    function automatic longint clicks(input longint p, input longint d);
        longint m;
        if (d >= 0) return (p + d) / N;
        m = -d;
        if (p == 0) return m / N;
        if (m >= p) return 1 + (m - p) / N;
        return 0;
    endfunction

    function automatic int corrections(input longint p, input longint d);
        longint t;
        t = p + d;
        if (t >= 0) return int'(t / N);
        return int'((-t + N - 1) / N);
    endfunction

    task automatic model_apply(input longint d);
        m_cross = m_cross + 32'(clicks(m_pos, d));
        m_pos   = mod_n(m_pos + d);
        if (m_pos == 0) m_land = m_land + 32'd1;
    endtask

    task automatic model_clear();
        m_pos   = 50;
        m_land  = '0;
        m_cross = '0;
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic peek(input logic [2:0] s, output logic [127:0] v);
        control = {3'b000, s};
        #1;
        v = dout;
    endtask

    task automatic check_state(input string tag);
        logic [127:0] v;
        peek(3'b010, v); chk({tag, "/pos"}, v, 128'(m_pos));
        peek(3'b011, v); chk({tag, "/land"}, v, 128'(m_land));
        peek(3'b100, v); chk({tag, "/cross"}, v, 128'(m_cross));
    endtask

    task automatic wait_ready(input string tag);
        int k;
        k = 0;
        control = 6'b000000;
        #1;
        while (!din_ready && k < 100) begin
            @(posedge clk); #1; k++;
        end
        chk({tag, "/ready_wait"}, din_ready, 1'b1);
    endtask

    function automatic logic [127:0] make_word(input longint d);
        logic [31:0] lo;
        lo = 32'(d);
        return {$urandom, $urandom, $urandom, lo};
    endfunction

    task automatic rotate(input longint d, output int lat);
        logic [127:0] word, v;
        int exp_lat;
        wait_ready("rot");
        word      = make_word(d);
        exp_lat   = corrections(m_pos, d) + 3;
        din       = word;
        din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
        model_apply(d);
        m_din = word;
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!dout_valid && lat < 5000);
        chk("rot/latency", lat, exp_lat);
        check_state("rot");
        peek(3'b000, v); chk("rot/din_echo", v, word);
        peek(3'b001, v); chk("rot/delta_sext", v, {{96{word[31]}}, word[31:0]});
        control = 6'b000000;
        @(posedge clk); #1;
        chk("rot/pulse_width", dout_valid, 1'b0);
    endtask

    task automatic soft_clear();
        wait_ready("clr");
        control = 6'b001000;
        @(posedge clk); #1;
        chk("clr/no_valid", dout_valid, 1'b0);
        control = 6'b000000;
        model_clear();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [127:0] v, word2, saved_din;
        int lat, cyc, pulses, first_pulse, second_pulse, bad_ready;
        logic armed;
        logic [31:0] land0, cross0;

        tbl[0] = '{-68, 82, 4};
        tbl[1] = '{-30, 52, 3};
        tbl[2] = '{ 48,  0, 4};
        tbl[3] = '{ -5, 95, 4};
        tbl[4] = '{ 60, 55, 4};
        tbl[5] = '{-55,  0, 3};
        tbl[6] = '{ -1, 99, 4};
        tbl[7] = '{-99,  0, 3};
        tbl[8] = '{ 14, 14, 3};
        tbl[9] = '{-82, 32, 4};

        rst_n     = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        control   = 6'b000010;
        model_clear();
        m_din = '0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("reset/din_ready", din_ready, 1'b1);
        chk("reset/dout_valid", dout_valid, 1'b0);
        chk("reset/pos50", dout, 128'd50);
        peek(3'b011, v); chk("reset/land", v, 128'd0);
        peek(3'b100, v); chk("reset/cross", v, 128'd0);
        peek(3'b000, v); chk("reset/din", v, 128'd0);
        peek(3'b111, v); chk("reset/sel_other", v, 128'd0);

        // spec rotation sequence
        for (int i = 0; i < 10; i++) begin
            rotate(tbl[i].delta, lat);
            chk("tbl/latency", lat, tbl[i].exp_lat);
            peek(3'b010, v); chk("tbl/pos", v, 128'(tbl[i].exp_pos));
        end
        peek(3'b011, v); chk("tbl/final_land", v, 128'd3);
        peek(3'b100, v); chk("tbl/final_cross", v, 128'd6);

        // large right turn
        soft_clear();
        check_state("after_clear");
        rotate(1000, lat);
        chk("big/latency13", lat, 13);
        peek(3'b010, v); chk("big/pos", v, 128'd50);
        peek(3'b100, v); chk("big/cross10", v, 128'd10);

        // left turns from / onto zero
        rotate(-50, lat);
        land0 = m_land; cross0 = m_cross;
        rotate(-100, lat);
        peek(3'b010, v); chk("left0/pos", v, 128'd0);
        peek(3'b011, v); chk("left0/land", v, 128'(land0 + 32'd1));
        peek(3'b100, v); chk("left0/cross", v, 128'(cross0 + 32'd1));
        land0 = m_land; cross0 = m_cross;
        rotate(0, lat);
        chk("zero/latency", lat, 3);
        peek(3'b011, v); chk("zero/land", v, 128'(land0 + 32'd1));
        peek(3'b100, v); chk("zero/cross", v, 128'(cross0));
        rotate(5, lat);
        cross0 = m_cross;
        rotate(-105, lat);
        peek(3'b010, v); chk("left5/pos", v, 128'd0);
        peek(3'b100, v); chk("left5/cross", v, 128'(cross0 + 32'd2));

        // din_valid held through a long rotation
        soft_clear();
        din       = make_word(1000);
        din_valid = 1'b1;
        @(posedge clk); #1;
        model_apply(1000);
        word2 = make_word(7);
        din   = word2;
        cyc = 0; pulses = 0; first_pulse = 0; second_pulse = 0; bad_ready = 0; armed = 1'b0;
        while (pulses < 2 && cyc < 60) begin
            @(posedge clk); #1; cyc++;
            if (armed) begin
                din_valid = 1'b0;
                armed = 1'b0;
            end
            if (dout_valid) begin
                pulses++;
                if (pulses == 1) first_pulse = cyc; else second_pulse = cyc;
            end
            if (pulses == 0 && din_ready) bad_ready++;
            if (din_ready && din_valid) armed = 1'b1;
        end
        din_valid = 1'b0;
        model_apply(7);
        chk("hold/pulses", pulses, 2);
        chk("hold/first_pulse", first_pulse, 13);
        chk("hold/busy_not_ready", bad_ready, 0);
        chk("hold/second_pulse", second_pulse, 18);
        check_state("hold");
        peek(3'b000, v); chk("hold/din_echo", v, word2);
        control = 6'b000000;

        // soft clear raised during NORM waits for IDLE
        wait_ready("defer");
        din       = make_word(1010);
        din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        control = 6'b001010;
        #1;
        chk("defer/old_pos", dout, 128'd57);
        lat = 3;
        while (!dout_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        chk("defer/latency", lat, 13);
        chk("defer/committed_pos", dout, 128'd67);
        @(posedge clk); #1;
        chk("defer/idle_clear_not_ready", din_ready, 1'b0);
        chk("defer/idle_pos_kept", dout, 128'd67);
        @(posedge clk); #1;
        chk("defer/cleared_pos", dout, 128'd50);
        chk("defer/no_valid", dout_valid, 1'b0);
        control = 6'b000000;
        model_clear();
        check_state("defer");

        // clear and din_valid together: clear wins
        rotate(3, lat);
        saved_din = m_din;
        wait_ready("clrwin");
        din       = make_word(20);
        din_valid = 1'b1;
        control   = 6'b001000;
        @(posedge clk); #1;
        din_valid = 1'b0;
        control   = 6'b000000;
        model_clear();
        pulses = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (dout_valid) pulses++;
        end
        chk("clrwin/no_pulse", pulses, 0);
        check_state("clrwin");
        peek(3'b000, v); chk("clrwin/din_kept", v, saved_din);

        // reset in the middle of a rotation
        rotate(-50, lat);
        wait_ready("rst");
        din       = make_word(1050);
        din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst/dout_valid", dout_valid, 1'b0);
        model_clear();
        m_din = '0;
        check_state("midrst_low");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        chk("midrst/ready_after", din_ready, 1'b1);
        pulses = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (dout_valid) pulses++;
        end
        chk("midrst/no_pulse", pulses, 0);
        check_state("midrst");
        peek(3'b000, v); chk("midrst/din_zero", v, 128'd0);

        // randomized rotations against the model
        for (int i = 0; i < 40; i++) begin
            longint d;
            if ($urandom_range(0, 7) == 0) d = 0;
            else d = longint'($urandom_range(0, 6000)) - 3000;
            if ($urandom_range(0, 15) == 0) soft_clear();
            control = 6'b000000;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            rotate(d, lat);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dial_coprocessor.md
DIAL_COPROCESSOR -- requirements
Module: dial_coprocessor

Interface
REQ-001 SHALL have parameter WIDTH_DIN, default 128: input word width.
REQ-002 SHALL have parameter WIDTH_DOUT, default 128: output word width.
REQ-003 SHALL have parameter WIDTH_COMPUTE, default 32: position, delta and counter width.
REQ-004 SHALL have parameter DIAL_SIZE, default 100: modulus N, number of dial positions.
REQ-005 SHALL have parameter START_POS, default 50: position after reset and after soft clear.
REQ-006 SHALL have one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port clk  in  1: sole clock, all state on rising edge.
REQ-008 SHALL have port rst_n  in  1: asynchronous active-low reset.
REQ-009 SHALL have port din  in  WIDTH_DIN: din[WIDTH_COMPUTE-1:0] is a signed rotation delta (negative = left); upper bits are ignored.
REQ-010 SHALL have port din_valid  in  1: din holds a rotation.
REQ-011 SHALL have port din_ready  out  1: block can accept a rotation.
REQ-012 SHALL have port dout  out  WIDTH_DOUT: selected result, combinational from registers.
REQ-013 SHALL have port dout_valid  out  1: one-cycle pulse when a rotation completes.
REQ-014 SHALL have port control  in  6: [2:0] output select, [3] soft clear, [5:4] reserved and ignored.

Function
REQ-015 SHALL accept a rotation only on a cycle where din_valid=1 and din_ready=1; din_valid without din_ready is ignored, so upstream holds din.
REQ-016 SHALL implement FSM IDLE->ADD->NORM->DONE->IDLE; din_ready=1 only in IDLE with control[3]=0.
REQ-017 SHALL on acceptance latch delta and din, then in ADD form tmp = pos + delta as a signed WIDTH_COMPUTE+1-bit value.
REQ-018 SHALL in NORM apply one correction per cycle: tmp<0 -> tmp+=N and cross+=1; tmp>=N -> tmp-=N and cross+=1; in range -> commit and go to DONE.
REQ-019 SHALL on commit set pos=tmp; land_cnt += (tmp==0); for delta<0 cross_cnt additionally +1 if tmp==0 and -1 if old pos==0.
REQ-020 SHALL therefore make cross_cnt equal the number of clicks ending on 0: right: floor((p+d)/N); left: p=0 -> floor(d/N); p>0 and d>=p -> 1+floor((d-p)/N); else 0.
REQ-021 SHALL treat delta=0 as valid: pos unchanged, land_cnt += (pos==0), cross_cnt unchanged.
REQ-022 SHALL assert dout_valid exactly in the DONE cycle, S+3 cycles after the accepting edge, where S is the number of corrections.
REQ-023 SHALL wrap both counters modulo 2^WIDTH_COMPUTE with no saturation.
REQ-024 SHALL select dout by control[2:0]: 000 last accepted din; 001 delta sign-extended; 010 pos zero-extended; 011 land_cnt; 100 cross_cnt; others zero; counters zero-extended.
REQ-025 SHALL on soft clear in IDLE set pos=START_POS and both counters to 0 with no dout_valid; soft clear outside IDLE is ignored until IDLE; clear with din_valid in the same cycle means clear wins and din is not accepted.
REQ-026 SHALL treat |delta| >= 2^(WIDTH_COMPUTE-1)-N as out of range, with result undefined and no hang required.

Reset
REQ-027 SHALL asynchronously on rst_n=0 set state=IDLE, pos=START_POS, land_cnt=0, cross_cnt=0, latched din/delta=0, dout_valid=0.
REQ-028 SHALL have din_ready=1 in the first cycle after rst_n deasserts.
REQ-029 SHALL abort a rotation on mid-operation reset with no dout_valid and no partial count update.

Structure
REQ-030 SHALL place FSM state enum and dout select codes in shared package dial_pkg.
REQ-031 SHALL implement the iterative normaliser (tmp, correction counter, in-range flag) as sub-module dial_norm; the FSM and output mux stay in dial_coprocessor.

Verification
REQ-032 SHALL verify: after reset, control=010 -> dout=50, din_ready=1, dout_valid=0.
REQ-033 SHALL verify: deltas -68,-30,48,-5,60,-55,-1,-99,14,-82 -> final pos 32, land_cnt 3, cross_cnt 6.
REQ-034 SHALL verify: pos 50, delta +1000 -> pos 50, cross_cnt +10, dout_valid 13 cycles after accept.
REQ-035 SHALL verify: pos 0, delta -100 -> pos 0, land +1, cross +1; pos 5, delta -105 -> pos 0, cross +2.
REQ-036 SHALL verify: din_valid held during NORM is not accepted until din_ready=1; soft clear during NORM is deferred; soft clear with din_valid in IDLE -> clear only.
REQ-037 SHALL verify: rst_n low in NORM -> pos 50, counts 0, no dout_valid pulse.
